ti_share_stage_reg: RTL

Pipeline register and refresh stage between the first and second component-function layers of the threshold-implemented 4-bit S-box.
- Captures the shared nibble produced by the stage-1 component functions.
- Optionally re-masks it with fresh randomness.
- Holds it glitch-stable for a programmable settle window.
- Presents it to the stage-2 component-function bank, whose functions each take an 8-bit slice of this bus, under a valid/ready handshake.

---
 rtl/ti_share_stage_reg_pkg.sv | 35 +++
 rtl/ti_share_stage_reg_if.sv | 32 +++
 rtl/ti_share_stage_reg_remask.sv | 33 +++
 rtl/ti_share_stage_reg.sv | 109 ++++++++++
 4 files changed

// File: rtl/ti_share_stage_reg_pkg.sv
// ---------------------------------------------------------------------------
// ti_pkg
// Shared definitions for the threshold-implemented S-box share stage:
//   - default share count / share width and settle-counter width
//   - FSM state encoding (IDLE, SETTLE, OUT)
//   - share_slice(): extracts share idx of width nbit from a flat share bus
// No ports (package).
// ---------------------------------------------------------------------------
package ti_pkg;

    localparam int NSHARE_D  = 3;
    localparam int NBIT_D    = 4;
    localparam int SETTLE_W  = 4;   // holds SETTLE_CYC-1 for SETTLE_CYC in 0..15

    // Widest bus / slice the helper handles; callers size-cast in and out.
    localparam int BUS_MAX   = 64;
    localparam int SLICE_MAX = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        OUT    = 2'd2
    } state_t;

    function automatic logic [SLICE_MAX-1:0] share_slice(
        input logic [BUS_MAX-1:0] bus,
        input int                 idx,
        input int                 nbit
    );
        logic [BUS_MAX-1:0] mask;
        mask = (BUS_MAX'(1) << nbit) - BUS_MAX'(1);
        return SLICE_MAX'((bus >> (idx * nbit)) & mask);
    endfunction

endpackage

// File: rtl/ti_share_stage_reg_if.sv
// ---------------------------------------------------------------------------
// ti_share_stage_reg_if
// Handshake bundle around the share stage register.
//   in_valid/in_ready/in_shares : stage-1 shares in (share i at [i*NBIT +: NBIT])
//   rnd/rnd_valid/rnd_ack       : fresh randomness in, consumed-pulse out
//   out_valid/out_ready/out_shares : registered shares to stage 2
// master = upstream/downstream environment, slave = the stage register.
// ---------------------------------------------------------------------------
interface ti_share_stage_reg_if #(
    parameter int NSHARE = 3,
    parameter int NBIT   = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [NSHARE*NBIT-1:0]   in_shares;
    logic [NSHARE*NBIT-1:0]   rnd;
    logic                     rnd_valid;
    logic                     rnd_ack;
    logic                     out_valid;
    logic                     out_ready;
    logic [NSHARE*NBIT-1:0]   out_shares;

    modport master (
        output in_valid, in_shares, rnd, rnd_valid, out_ready,
        input  in_ready, rnd_ack, out_valid, out_shares
    );

    modport slave (
        input  in_valid, in_shares, rnd, rnd_valid, out_ready,
        output in_ready, rnd_ack, out_valid, out_shares
    );
endinterface

// File: rtl/ti_share_stage_reg_remask.sv
// ---------------------------------------------------------------------------
// ti_remask
// Combinational share-rotating refresh:
//   o_share[i] = i_share[i] ^ r[i] ^ r[(i-1) mod NSHARE]
// Every r_j lands in exactly two shares, so the XOR of all shares is kept.
// Ports:
//   i_shares : NSHARE*NBIT  input shares
//   i_rnd    : NSHARE*NBIT  fresh randomness
//   o_shares : NSHARE*NBIT  refreshed shares
// ---------------------------------------------------------------------------
module ti_remask
    import ti_pkg::*;
#(
    parameter int NSHARE = NSHARE_D,
    parameter int NBIT   = NBIT_D
) (
    input  logic [NSHARE*NBIT-1:0] i_shares,
    input  logic [NSHARE*NBIT-1:0] i_rnd,
    output logic [NSHARE*NBIT-1:0] o_shares
);

    for (genvar gi = 0; gi < NSHARE; gi++) begin : g_share
        localparam int PREV = (gi + NSHARE - 1) % NSHARE;
        logic [NBIT-1:0] w_s;
        logic [NBIT-1:0] w_r_own;
        logic [NBIT-1:0] w_r_prev;
        assign w_s      = NBIT'(share_slice(BUS_MAX'(i_shares), gi,   NBIT));
        assign w_r_own  = NBIT'(share_slice(BUS_MAX'(i_rnd),    gi,   NBIT));
        assign w_r_prev = NBIT'(share_slice(BUS_MAX'(i_rnd),    PREV, NBIT));
        assign o_shares[gi*NBIT +: NBIT] = w_s ^ w_r_own ^ w_r_prev;
    end

endmodule

// File: rtl/ti_share_stage_reg.sv
// ---------------------------------------------------------------------------
// ti_share_stage_reg
// Pipeline register + optional refresh between the stage-1 and stage-2
// component-function layers of a threshold-implemented 4-bit S-box. The
// captured shares are held unchanged through a SETTLE_CYC-cycle settle
// window and the OUT phase, isolating glitches between nonlinear layers.
// Build option: define TI_REMASK_EN to re-mask with bus.rnd on capture
// (in_ready gated by rnd_valid, rnd_ack pulses). Undefined: shares pass
// through, rnd/rnd_valid ignored, rnd_ack = 0.
// Ports:
//   clk : clock
//   rst : synchronous active-high reset
//   bus : ti_share_stage_reg_if.slave (in/rnd/out handshakes, see interface)
// ---------------------------------------------------------------------------
module ti_share_stage_reg
    import ti_pkg::*;
#(
    parameter int NSHARE     = NSHARE_D,
    parameter int NBIT       = NBIT_D,
    parameter int SETTLE_CYC = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    ti_share_stage_reg_if.slave  bus
);

    localparam int W = NSHARE * NBIT;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [SETTLE_W-1:0]   r_cnt;
    logic [SETTLE_W-1:0]   w_cnt_nxt;
    logic [W-1:0]          r_shares_p1;
    logic [W-1:0]          w_shares_p0;
    logic                  w_in_ready;
    logic                  w_fire;

`ifdef TI_REMASK_EN
    ti_remask #(
        .NSHARE (NSHARE),
        .NBIT   (NBIT)
    ) u_remask (
        .i_shares (bus.in_shares),
        .i_rnd    (bus.rnd),
        .o_shares (w_shares_p0)
    );
    // Accept only when fresh randomness is available to consume.
    assign w_in_ready = !rst && (r_state == IDLE) && bus.rnd_valid;
    assign bus.rnd_ack = w_fire;
`else
    logic w_unused_rnd;
    assign w_unused_rnd = ^{bus.rnd, bus.rnd_valid};
    assign w_shares_p0  = bus.in_shares;
    assign w_in_ready   = !rst && (r_state == IDLE);
    assign bus.rnd_ack  = 1'b0;
`endif

    assign w_fire        = w_in_ready && bus.in_valid;
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == OUT);
    assign bus.out_shares = r_shares_p1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_fire) begin
                    if (SETTLE_CYC > 0) begin
                        w_state_nxt = SETTLE;
                        w_cnt_nxt   = SETTLE_W'(SETTLE_CYC - 1);
                    end else begin
                        w_state_nxt = OUT;
                    end
                end
            end
            SETTLE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = OUT;
                end else begin
                    w_cnt_nxt = r_cnt - SETTLE_W'(1);
                end
            end
            OUT: begin
                // No bypass: IDLE must be re-entered before the next capture.
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // p0 -> p1: capture the (refreshed) shares; held until the next capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_shares_p1 <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_fire) begin
                r_shares_p1 <= w_shares_p0;
            end
        end
    end

endmodule
